// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush sequencer with stall watchdog; PIPE_CTRL_PERF_EN adds per-source stall counters.
module pipe_ctrl #(
  parameter int          STALL_TIMEOUT = 1024,
  parameter logic [31:0] INT_VECTOR    = 32'h00000020,
  parameter logic [31:0] EXC_VECTOR    = 32'h00000040,
  parameter int          CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic [1:0]        state_o,
  output logic              stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_if_o,
  output logic [CNT_W-1:0]  perf_id_o,
  output logic [CNT_W-1:0]  perf_ex_o,
  output logic [CNT_W-1:0]  perf_mem_o
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STALL_TIMEOUT - 1);
  state_t state;
  logic [CNT_W-1:0] stall_cnt;
  logic exc, stalled;
  assign exc = |excepttype_i;
  assign stalled = |stall_o;
  assign state_o = state;
  // Reset doubles as a flush so a mid-stall reset abandons the stall at once.
  always_comb begin
    stall_o  = (rst || exc) ? 6'b000000 :
               stallreq_mem_i ? 6'b011111 :
               stallreq_ex_i  ? 6'b001111 :
               stallreq_id_i  ? 6'b000111 :
               stallreq_if_i  ? 6'b000011 : 6'b000000;
    flush_o  = rst || exc;
    new_pc_o = (rst || !exc) ? 32'h0 :
               excepttype_i == 32'h1 ? INT_VECTOR :
               excepttype_i == 32'he ? cp0_epc_i : EXC_VECTOR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      stall_cnt       <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      state     <= exc ? FLUSH : stalled ? STALL : RUN;
      stall_cnt <= (!stalled || flush_o) ? '0 : &stall_cnt ? stall_cnt : stall_cnt + 1'b1;
      if (stalled && stall_cnt == LIM) stall_timeout_o <= 1'b1;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [3:0] win;
  logic [CNT_W-1:0] perf [4];
  always_comb begin
    win    = 4'b0000;
    win[3] = !flush_o && stallreq_mem_i;
    win[2] = !flush_o && !stallreq_mem_i && stallreq_ex_i;
    win[1] = !flush_o && !stallreq_mem_i && !stallreq_ex_i && stallreq_id_i;
    win[0] = !flush_o && !stallreq_mem_i && !stallreq_ex_i && !stallreq_id_i && stallreq_if_i;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (rst) perf[i] <= '0;
      else if (win[i] && !(&perf[i])) perf[i] <= perf[i] + 1'b1;
  end
  assign perf_if_o  = perf[0];
  assign perf_id_o  = perf[1];
  assign perf_ex_o  = perf[2];
  assign perf_mem_o = perf[3];
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus randomized checks of pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
  localparam int T = 8;
  logic clk = 1'b0, rst;
  logic rif, rid, rex, rmem;
  logic [31:0] exct, epc;
  logic [5:0] stall;
  logic flush, tout;
  logic [31:0] npc;
  logic [1:0] st;
  int checks = 0, failures = 0;
  int m_state, m_run, m_to, m_known;
  int m_perf [4];
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] p_if, p_id, p_ex, p_mem;
`endif
  always #5 clk = ~clk;
  pipe_ctrl #(.STALL_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .stallreq_if_i(rif), .stallreq_id_i(rid),
    .stallreq_ex_i(rex), .stallreq_mem_i(rmem), .excepttype_i(exct),
    .cp0_epc_i(epc), .stall_o(stall), .flush_o(flush), .new_pc_o(npc),
    .state_o(st), .stall_timeout_o(tout)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_if_o(p_if), .perf_id_o(p_id), .perf_ex_o(p_ex), .perf_mem_o(p_mem)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic a, input logic b, input logic c,
                     input logic d, input logic [31:0] e, input logic [31:0] p);
    int lvl, es, ef;
    logic [31:0] ep;
    @(negedge clk);
    rst = r; rif = a; rid = b; rex = c; rmem = d; exct = e; epc = p;
    #1;
    // Highest active source picks how many leading stages hold: level k holds k+1 stages.
    lvl = d ? 4 : c ? 3 : b ? 2 : a ? 1 : 0;
    if (r || e != 0) lvl = 0;
    es = lvl == 0 ? 0 : (1 << (lvl + 1)) - 1;
    ef = (r || e != 0) ? 1 : 0;
    ep = (r || e == 0) ? 32'h0 : e == 32'h1 ? 32'h20 : e == 32'he ? p : 32'h40;
    check("stall", {26'h0, stall}, es);
    check("flush", {31'h0, flush}, ef);
    check("new_pc", npc, ep);
    if (m_known != 0) begin
      check("state", {30'h0, st}, m_state);
      check("timeout", {31'h0, tout}, m_to);
`ifdef PIPE_CTRL_PERF_EN
      check("perf_if", {16'h0, p_if}, m_perf[0]);
      check("perf_id", {16'h0, p_id}, m_perf[1]);
      check("perf_ex", {16'h0, p_ex}, m_perf[2]);
      check("perf_mem", {16'h0, p_mem}, m_perf[3]);
`endif
    end
    @(posedge clk);
    if (r) begin
      m_state = 0; m_run = 0; m_to = 0; m_known = 1;
      for (int i = 0; i < 4; i++) m_perf[i] = 0;
    end else begin
      m_state = e != 0 ? 2 : (a | b | c | d) ? 1 : 0;
      m_run = es != 0 ? m_run + 1 : 0;
      if (m_run >= T) m_to = 1;
      if (lvl > 0 && m_perf[lvl-1] < 65535) m_perf[lvl-1]++;
    end
  endtask
  initial begin
    logic [31:0] codes [7];
    logic [31:0] e;
    codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'ha; codes[3] = 32'hc;
    codes[4] = 32'hd; codes[5] = 32'he; codes[6] = 32'h7;
    m_known = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'he, 32'h00400100);
    cyc(0, 0, 0, 0, 1, 32'h1, 32'h00400100);
    cyc(0, 0, 0, 0, 1, 32'hc, 32'h00400100);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h8, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      e = $urandom_range(0, 7) == 0 ? codes[$urandom_range(0, 6)] : 32'h0;
      if (e == 32'h7) e = $urandom | 32'h1000;
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, e, $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
